load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory interface for the pipelined core.
- Takes one load/store per request from the MEM stage and issues a word-aligned bus transaction with byte enables.
- Waits for grant and, for loads, for read response; then lane-extracts and sign/zero-extends load data.
- Stalls the pipeline while busy; flags misaligned/illegal-size accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 64, cycles spent in REQ+WAIT before lsu_bus_err; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- lsu_valid  input  1  MEM stage holds a memory op; held stable until lsu_done
- lsu_is_store  input  1  1 = store, 0 = load
- lsu_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- lsu_unsigned  input  1  loads only: 1 = zero-extend (LBU/LHU)
- lsu_addr  input  32  byte address
- lsu_wdata  input  32  store data, low-aligned
- lsu_rdata  output  32  extended load result, valid when lsu_done && !lsu_is_store
- lsu_done  output  1  one-cycle completion pulse
- lsu_stall  output  1  lsu_valid && !lsu_done (combinational)
- lsu_misaligned  output  1  with lsu_done: alignment or size fault
- lsu_bus_err  output  1  with lsu_done: timeout fault
- mem_req  output  1  bus request
- mem_gnt  input  1  request accepted this cycle
- mem_we  output  1  write request
- mem_be  output  4  byte enables
- mem_addr  output  32  {addr[31:2], 2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_rvalid  input  1  read data valid
- mem_rdata  input  32  read word

Behaviour:
- Reset: state IDLE, timeout counter 0. All outputs 0: mem_req, mem_we, mem_be, mem_addr, mem_wdata, lsu_done, lsu_rdata, lsu_misaligned, lsu_bus_err.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, lsu_valid=1: latch addr, wdata, size, unsigned, is_store.
  - Fault if size=11, size=10 with addr[1:0]!=0, or size=01 with addr[0]!=0. On fault go to DONE with misaligned=1; no bus activity.
  - Otherwise go to REQ.
- REQ: mem_req=1; mem_addr, mem_we, mem_be and mem_wdata come from the latched values.
  - On mem_gnt: store -> DONE; load -> WAIT.
  - mem_req deasserts the cycle after grant.
- WAIT: mem_req=0. On mem_rvalid: capture mem_rdata, extract, go to DONE.
  - mem_rvalid in the same cycle as mem_gnt while in REQ is not accepted. The responder delivers rvalid at least one cycle after grant.
- DONE: lsu_done=1 for exactly one cycle, with lsu_rdata and fault flags stable. Next state is IDLE; a new request is accepted no earlier than the cycle after DONE.
- Minimum latency, measured from the cycle lsu_valid rises in IDLE:
  - store with same-cycle grant: done at cycle 3.
  - load with rvalid one cycle after grant: done at cycle 4.
  - fault: done at cycle 2.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- Store data lane replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction: shift mem_rdata right by 8*addr[1:0], take the low 8 or 16 bits.
  - Sign-extend unless lsu_unsigned=1; word loads pass through.
  - lsu_rdata is 0 for stores and faults.
- Timeout: counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES (nonzero), go to DONE with bus_err=1 and drop mem_req.
  - A later stray mem_rvalid/mem_gnt in IDLE or DONE is ignored.
- Reset mid-operation: next cycle is IDLE with mem_req=0 and no lsu_done pulse; in-flight responses are ignored.
- lsu_valid dropping before done is a protocol violation; the FSM still completes the latched op.

Test Plan:
- SW addr 0x0000_0104, wdata 0xDEADBEEF, gnt same cycle as req -> mem_addr 0x104, be 1111, wdata 0xDEADBEEF, we=1, done 3 cycles after valid, stall high until then.
- SB addr 0x0000_0203, wdata 0x0000_00A5 -> mem_addr 0x200, be 1000, wdata 0xA5A5A5A5.
- LB addr 0x0000_0102, mem_rdata 0x12_80_34_56 one cycle after gnt -> lsu_rdata 0xFFFFFF80. Same with lsu_unsigned=1 -> 0x00000080.
- LH addr 0x0000_0102, mem_rdata 0x8001_1234 -> 0xFFFF8001. LW with grant delayed 3 cycles -> mem_req held 3 cycles, data passed through unchanged.
- LW addr 0x0000_0101 and size=11 -> lsu_done+lsu_misaligned at cycle 2, mem_req never asserted, lsu_rdata 0.
- TIMEOUT_CYCLES=4, load with mem_gnt held 0 -> bus_err+done after 4 cycles in REQ, mem_req drops. Separately, rst asserted in WAIT -> IDLE next cycle with no done pulse, and a following rvalid is ignored.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory
// fabric (slave).
//   req/we/be/addr/wdata : request channel, driven by the master
//   gnt                  : request accepted this cycle, driven by the slave
//   rvalid/rdata         : read response, driven by the slave
interface load_store_unit_if;
    logic        req;
    logic        gnt;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory interface.
// Accepts one load/store from the MEM stage, issues a word-aligned bus
// request with byte enables, waits for grant (and read data for loads),
// then returns the lane-extracted, sign/zero-extended load result.
//   clk, rst            : clock, synchronous active-high reset
//   lsu_*  (inputs)     : op request from MEM stage, held until lsu_done
//   lsu_rdata/done      : registered result and one-cycle completion pulse
//   lsu_misaligned      : completion with alignment/size fault
//   lsu_bus_err         : completion with bus timeout
//   lsu_stall           : combinational pipeline stall
//   mem                 : data-memory bus (master side)
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lsu_valid,
    input  logic                     lsu_is_store,
    input  logic [1:0]               lsu_size,
    input  logic                     lsu_unsigned,
    input  logic [31:0]              lsu_addr,
    input  logic [31:0]              lsu_wdata,
    output logic [31:0]              lsu_rdata,
    output logic                     lsu_done,
    output logic                     lsu_stall,
    output logic                     lsu_misaligned,
    output logic                     lsu_bus_err,
    load_store_unit_if.master        mem
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          size_q, size_d;
    logic [1:0]          lo_q, lo_d;
    logic                uns_q, uns_d;
    logic                store_q, store_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   maddr_q, maddr_d;
    logic [DATA_W-1:0]   mwdata_q, mwdata_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mis_q, mis_d;
    logic                berr_q, berr_d;

    logic                fault_c;
    logic [CNT_W-1:0]    cnt_inc_c;
    logic                timeout_c;

    // Byte enables for an aligned access of the given size.
    function automatic logic [BE_W-1:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   byte_en = 4'b0001 << lo;
            2'b01:   byte_en = 4'b0011 << {lo[1], 1'b0};
            default: byte_en = 4'b1111;
        endcase
    endfunction

    // Replicate low-aligned store data across every lane it could land in.
    function automatic logic [DATA_W-1:0] store_lanes(input logic [1:0] size, input logic [DATA_W-1:0] wd);
        case (size)
            2'b00:   store_lanes = {4{wd[7:0]}};
            2'b01:   store_lanes = {2{wd[15:0]}};
            default: store_lanes = wd;
        endcase
    endfunction

    // Shift the addressed lane down and extend to a full word.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                      input logic [1:0]        size,
                                                      input logic [1:0]        lo,
                                                      input logic              uns);
        logic [DATA_W-1:0] sh;
        sh = word >> {lo, 3'b000};
        case (size)
            2'b00:   load_extend = uns ? {24'd0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
            2'b01:   load_extend = uns ? {16'd0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
            default: load_extend = sh;   // word accesses are aligned, so sh == word
        endcase
    endfunction

    // Alignment / illegal-size check on the incoming op.
    assign fault_c = (lsu_size == 2'b11)
                   || ((lsu_size == 2'b10) && (lsu_addr[1:0] != 2'b00))
                   || ((lsu_size == 2'b01) && lsu_addr[0]);

    // Bus-wait timeout; a completing handshake in the same cycle wins.
    assign cnt_inc_c = cnt_q + CNT_W'(1);
    assign timeout_c = (TIMEOUT_CYCLES != 32'd0) && (cnt_inc_c >= CNT_W'(TIMEOUT_CYCLES));

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        lo_d     = lo_q;
        uns_d    = uns_q;
        store_d  = store_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        be_d     = be_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        done_d   = 1'b0;
        rdata_d  = rdata_q;
        mis_d    = mis_q;
        berr_d   = berr_q;

        unique case (state_q)
            IDLE: begin
                if (lsu_valid) begin
                    size_d  = lsu_size;
                    lo_d    = lsu_addr[1:0];
                    uns_d   = lsu_unsigned;
                    store_d = lsu_is_store;
                    if (fault_c) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d  = REQ;
                        cnt_d    = '0;
                        req_d    = 1'b1;
                        we_d     = lsu_is_store;
                        be_d     = byte_en(lsu_size, lsu_addr[1:0]);
                        maddr_d  = {lsu_addr[31:2], 2'b00};
                        mwdata_d = store_lanes(lsu_size, lsu_wdata);
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_inc_c;
                if (mem.gnt || timeout_c) begin
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    be_d     = '0;
                    maddr_d  = '0;
                    mwdata_d = '0;
                end
                if (mem.gnt) begin
                    if (store_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (timeout_c) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    berr_d  = 1'b1;
                    rdata_d = '0;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc_c;
                if (mem.rvalid) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    rdata_d = load_extend(mem.rdata, size_q, lo_q, uns_q);
                end else if (timeout_c) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    berr_d  = 1'b1;
                    rdata_d = '0;
                end
            end
            DONE: begin
                // Result and flags are only meaningful during the done pulse.
                state_d = IDLE;
                rdata_d = '0;
                mis_d   = 1'b0;
                berr_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            size_q   <= '0;
            lo_q     <= '0;
            uns_q    <= 1'b0;
            store_q  <= 1'b0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            lo_q     <= lo_d;
            uns_q    <= uns_d;
            store_q  <= store_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            be_q     <= be_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
            berr_q   <= berr_d;
        end
    end

    assign mem.req        = req_q;
    assign mem.we         = we_q;
    assign mem.be         = be_q;
    assign mem.addr       = maddr_q;
    assign mem.wdata      = mwdata_q;
    assign lsu_rdata      = rdata_q;
    assign lsu_done       = done_q;
    assign lsu_misaligned = mis_q;
    assign lsu_bus_err    = berr_q;
    assign lsu_stall      = lsu_valid && !done_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed op table, a behavioural model that
// derives bus fields, result and completion cycle from each op, and one
// negedge compare process checking the DUT against the current expectation.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid;
    logic        lsu_is_store;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_done;
    logic        lsu_stall;
    logic        lsu_misaligned;
    logic        lsu_bus_err;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_valid      (lsu_valid),
        .lsu_is_store   (lsu_is_store),
        .lsu_size       (lsu_size),
        .lsu_unsigned   (lsu_unsigned),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_rdata      (lsu_rdata),
        .lsu_done       (lsu_done),
        .lsu_stall      (lsu_stall),
        .lsu_misaligned (lsu_misaligned),
        .lsu_bus_err    (lsu_bus_err),
        .mem            (bus.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expectations for the current cycle
    bit          chk_en = 1'b0;
    bit          e_zero, e_req, e_done, e_we, e_mis, e_berr;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_rdata;

    typedef struct {
        bit          is_store;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          g;          // REQ cycle carrying gnt (1-based), 0 = never
        int          r;          // cycles from gnt to rvalid
        int          exp_lat;    // hand-computed: cycle of done, valid-rise cycle = 1
        logic [31:0] exp_rdata;  // hand-computed result
        logic [3:0]  exp_be;     // hand-computed byte enables
    } op_t;

    op_t ops[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process
    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_req",   32'(bus.req),   32'(e_req));
            check("lsu_done",  32'(lsu_done),  32'(e_done));
            check("lsu_stall", 32'(lsu_stall), 32'(lsu_valid && !e_done));
            if (e_req || e_zero) begin
                check("mem_we",    32'(bus.we), 32'(e_we));
                check("mem_be",    32'(bus.be), 32'(e_be));
                check("mem_addr",  bus.addr,    e_addr);
                check("mem_wdata", bus.wdata,   e_wdata);
            end
            if (e_done || e_zero) begin
                check("lsu_rdata",      lsu_rdata,            e_rdata);
                check("lsu_misaligned", 32'(lsu_misaligned), 32'(e_mis));
                check("lsu_bus_err",    32'(lsu_bus_err),    32'(e_berr));
            end
        end
    end

    task automatic set_idle_exp(input bit zero);
        e_zero = zero; e_req = 1'b0; e_done = 1'b0;
        e_we = 1'b0; e_be = '0; e_addr = '0; e_wdata = '0;
        e_rdata = '0; e_mis = 1'b0; e_berr = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic run_op(input op_t op, input string tag);
        int          nb, lo, e, done_c, req_last;
        bit          fault, berr;
        logic [3:0]  be;
        logic [31:0] wd, rd;
        longint      v;

        // Model: what the access must look like on the bus and in the result
        nb    = 1 << op.size;
        lo    = int'(op.addr % 32'd4);
        fault = (op.size == 2'd3) || ((lo % nb) != 0);
        for (int i = 0; i < 4; i++) begin
            be[i]          = (i >= lo) && (i < lo + nb);
            wd[8*i +: 8]   = op.wdata[8*(i % nb) +: 8];
        end
        if (fault) begin
            done_c = 1; req_last = 0; berr = 1'b0;
        end else begin
            e = op.is_store ? op.g : op.g + op.r;
            if (op.g != 0 && e <= TO) begin
                done_c = e + 1; req_last = op.g; berr = 1'b0;
            end else begin
                done_c = TO + 1; berr = 1'b1;
                req_last = (op.g != 0 && op.g < TO) ? op.g : TO;
            end
        end
        rd = '0;
        if (!fault && !berr && !op.is_store) begin
            v = 0;
            for (int i = 0; i < nb; i++)
                v += longint'(op.rdata[8*(lo+i) +: 8]) << (8*i);
            if (!op.uns && nb < 4 && v >= (longint'(1) << (8*nb - 1)))
                v -= longint'(1) << (8*nb);
            rd = 32'(v);
        end

        // Pin the model against hand-computed values
        check({tag, "_model_lat"},   32'(done_c + 1), 32'(op.exp_lat));
        check({tag, "_model_rdata"}, rd,              op.exp_rdata);
        if (!fault) check({tag, "_model_be"}, 32'(be), 32'(op.exp_be));

        for (int c = 0; c <= done_c + 1; c++) begin
            @(posedge clk); #1;
            lsu_valid    = (c <= done_c);
            lsu_is_store = op.is_store;
            lsu_size     = op.size;
            lsu_unsigned = op.uns;
            lsu_addr     = op.addr;
            lsu_wdata    = op.wdata;
            bus.gnt      = !fault && op.g != 0 && c == op.g;
            bus.rvalid   = !fault && !op.is_store && op.g != 0 && c == op.g + op.r;
            bus.rdata    = bus.rvalid ? op.rdata : $urandom;
            e_zero  = 1'b0;
            e_req   = (c >= 1) && (c <= req_last);
            e_done  = (c == done_c);
            e_we    = op.is_store;
            e_be    = be;
            e_addr  = {op.addr[31:2], 2'b00};
            e_wdata = wd;
            e_rdata = rd;
            e_mis   = fault;
            e_berr  = berr;
            chk_en  = 1'b1;
            @(negedge clk);
        end
        bus.gnt = 1'b0; bus.rvalid = 1'b0; lsu_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ops[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,         1, 0, 3, 32'h0,         4'hF};
        ops[1]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0203, 32'h0000_00A5, 32'h0,         1, 0, 3, 32'h0,         4'h8};
        ops[2]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0102, 32'h0,         32'h1280_3456, 1, 1, 4, 32'hFFFF_FF80, 4'h4};
        ops[3]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0102, 32'h0,         32'h1280_3456, 1, 1, 4, 32'h0000_0080, 4'h4};
        ops[4]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0,         32'h8001_1234, 1, 1, 4, 32'hFFFF_8001, 4'hC};
        ops[5]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         32'hCAFE_F00D, 3, 1, 6, 32'hCAFE_F00D, 4'hF};
        ops[6]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0,         32'h1111_1111, 0, 0, 2, 32'h0,         4'h0};
        ops[7]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0,         32'h2222_2222, 0, 0, 2, 32'h0,         4'h0};
        ops[8]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0302, 32'h1234_ABCD, 32'h0,         2, 0, 4, 32'h0,         4'hC};
        ops[9]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0100, 32'h0,         32'h0000_8001, 1, 2, 5, 32'h0000_8001, 4'h3};
        ops[10] = '{1'b1, 2'd2, 1'b0, 32'h0000_0106, 32'h5555_5555, 32'h0,         0, 0, 2, 32'h0,         4'h0};
        ops[11] = '{1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0,         32'h3333_3333, 0, 0, 6, 32'h0,         4'hF};

        rst = 1'b1;
        lsu_valid = 1'b0; lsu_is_store = 1'b0; lsu_size = 2'd0; lsu_unsigned = 1'b0;
        lsu_addr = '0; lsu_wdata = '0;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;

        // Reset state: every output zero
        repeat (2) begin
            @(posedge clk); #1;
            set_idle_exp(1'b1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        set_idle_exp(1'b1);
        @(negedge clk);

        for (int k = 0; k < 12; k++) run_op(ops[k], $sformatf("op%0d", k));

        // Stray gnt/rvalid after the timed-out op must be ignored
        repeat (3) begin
            @(posedge clk); #1;
            bus.gnt = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'hBAD0_BAD0;
            set_idle_exp(1'b0);
            @(negedge clk);
        end
        bus.gnt = 1'b0; bus.rvalid = 1'b0;

        // Reset while waiting for read data: no done, late rvalid ignored
        @(posedge clk); #1;
        set_idle_exp(1'b0);
        lsu_valid = 1'b1; lsu_is_store = 1'b0; lsu_size = 2'd2; lsu_unsigned = 1'b0;
        lsu_addr = 32'h0000_0100; lsu_wdata = '0;
        @(negedge clk);
        @(posedge clk); #1;
        bus.gnt = 1'b1;
        e_req = 1'b1; e_we = 1'b0; e_be = 4'hF; e_addr = 32'h0000_0100; e_wdata = '0;
        @(negedge clk);
        @(posedge clk); #1;
        bus.gnt = 1'b0; rst = 1'b1;
        set_idle_exp(1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0; lsu_valid = 1'b0;
        bus.rvalid = 1'b1; bus.rdata = 32'h7777_7777;
        set_idle_exp(1'b1);
        @(negedge clk);
        repeat (3) begin
            @(posedge clk); #1;
            bus.rvalid = 1'b0;
            set_idle_exp(1'b1);
            @(negedge clk);
        end

        // Normal operation resumes after the reset
        run_op(ops[0], "post_rst");

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
